seg7_capture_decoder: RTL and testbench

//  Receive-side counterpart of the hex-to-7-segment encoder. Samples an external multiplexed,

---
 rtl/seg7_pkg.sv | 35 +++
 rtl/seg7_stability_filter.sv | 65 ++++++
 rtl/seg7_capture_decoder.sv | 119 +++++++++++
 tb/tb_seg7_capture_decoder.sv | 270 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/seg7_pkg.sv
// Shared 7-segment definitions: active-low code table, blank pattern and the table
// inversion used by both the encoder and the capture decoder.
package seg7_pkg;

  localparam logic [6:0] SEG7_BLANK = 7'h7F;

  localparam logic [6:0] SEG7_CODE [16] = '{
    7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
    7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E
  };

  typedef enum logic [1:0] {
    ST_SETTLE = 2'd0,
    ST_EVAL   = 2'd1,
    ST_HOLD   = 2'd2
  } cap_state_e;

  typedef struct packed {
    logic       hit;
    logic [3:0] nibble;
  } seg7_dec_t;

  function automatic seg7_dec_t seg7_decode(input logic [6:0] seg);
    seg7_dec_t res;
    res = '0;
    for (int i = 0; i < 16; i++) begin
      if (seg == SEG7_CODE[i]) begin
        res.hit    = 1'b1;
        res.nibble = i[3:0];
      end
    end
    return res;
  endfunction

endpackage

// File: rtl/seg7_stability_filter.sv
// Synchronises the display bus and counts how long the synced word has been unchanged.
// stable_evt_o fires once, on the cycle the run of identical samples becomes long enough.
module seg7_stability_filter #(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 16,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                clk_i,
  input  logic                rst_ni,
  input  logic [6:0]          seg_i,
  input  logic [DIGITS-1:0]   dig_en_i,
  output logic [DIGITS+6:0]   p_o,
  output logic                changed_o,
  output logic                stable_evt_o
);

  localparam int W  = DIGITS + 7;
  localparam int CW = $clog2(STABLE_CYCLES + 1);

  logic [W-1:0]  sync_q [SYNC_STAGES];
  logic [W-1:0]  prev_q;
  logic [CW-1:0] cnt_q;
  logic [CW-1:0] cnt_d;

  genvar gi;
  generate
    for (gi = 0; gi < SYNC_STAGES; gi++) begin : g_sync
      if (gi == 0) begin : g_first
        always_ff @(posedge clk_i or negedge rst_ni) begin
          if (!rst_ni) sync_q[gi] <= '1;
          else         sync_q[gi] <= {dig_en_i, seg_i};
        end
      end else begin : g_rest
        always_ff @(posedge clk_i or negedge rst_ni) begin
          if (!rst_ni) sync_q[gi] <= '1;
          else         sync_q[gi] <= sync_q[gi-1];
        end
      end
    end
  endgenerate

  assign p_o       = sync_q[SYNC_STAGES-1];
  assign changed_o = (p_o != prev_q);

  always_comb begin
    cnt_d = cnt_q;
    if (changed_o)                           cnt_d = '0;
    else if (cnt_q != CW'(STABLE_CYCLES))    cnt_d = cnt_q + 1'b1;
  end

  // Fires on the edge where the counter would step to STABLE_CYCLES-1, so the
  // classification registers on that same edge.
  assign stable_evt_o = !changed_o && (cnt_q == CW'(STABLE_CYCLES - 2));

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      prev_q <= '1;
      cnt_q  <= '0;
    end else begin
      prev_q <= p_o;
      cnt_q  <= cnt_d;
    end
  end

endmodule

// File: rtl/seg7_capture_decoder.sv
// Reads back a multiplexed active-low 7-segment bus: each stable pattern is classified once
// and written into a per-digit nibble register file with update/error strobes.
module seg7_capture_decoder
  import seg7_pkg::*;
#(
  parameter int DIGITS        = 4,
  parameter int STABLE_CYCLES = 16,
  parameter int SYNC_STAGES   = 2
) (
  input  logic                      clk_i,
  input  logic                      rst_ni,
  input  logic [6:0]                seg_in_i,
  input  logic [DIGITS-1:0]         dig_en_i,
  input  logic                      clear_i,
  output logic [4*DIGITS-1:0]       values_o,
  output logic [DIGITS-1:0]         digit_valid_o,
  output logic                      update_o,
  output logic [$clog2(DIGITS)-1:0] update_idx_o,
  output logic                      err_o
);

  localparam int IW = $clog2(DIGITS);

  logic [DIGITS+6:0] p;
  logic              changed;
  logic              stable_evt;

  seg7_stability_filter #(
    .DIGITS        (DIGITS),
    .STABLE_CYCLES (STABLE_CYCLES),
    .SYNC_STAGES   (SYNC_STAGES)
  ) u_filter (
    .clk_i        (clk_i),
    .rst_ni       (rst_ni),
    .seg_i        (seg_in_i),
    .dig_en_i     (dig_en_i),
    .p_o          (p),
    .changed_o    (changed),
    .stable_evt_o (stable_evt)
  );

  logic [DIGITS-1:0] dig_s;
  logic [6:0]        seg_s;
  logic              is_gap;
  logic              is_single;
  logic [IW-1:0]     dig_idx;
  seg7_dec_t         dec;

  assign dig_s     = p[DIGITS+6:7];
  assign seg_s     = p[6:0];
  assign is_gap    = &dig_s;
  assign is_single = $onehot(~dig_s);
  assign dec       = seg7_decode(seg_s);

  always_comb begin
    dig_idx = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (!dig_s[i]) dig_idx = IW'(i);
    end
  end

  cap_state_e               state_q;
  logic [4*DIGITS-1:0]      values_q;
  logic [DIGITS-1:0]        valid_q;
  logic                     update_q;
  logic [IW-1:0]            idx_q;
  logic                     err_q;

  // Classification is registered on the SETTLE->EVAL edge, so the strobes are
  // visible exactly while the FSM sits in EVAL.
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      state_q  <= ST_SETTLE;
      values_q <= '0;
      valid_q  <= '0;
      update_q <= 1'b0;
      idx_q    <= '0;
      err_q    <= 1'b0;
    end else begin
      update_q <= 1'b0;
      err_q    <= 1'b0;
      case (state_q)
        ST_SETTLE: begin
          if (stable_evt) begin
            state_q <= ST_EVAL;
            if (!clear_i && !is_gap) begin
              if (is_single && dec.hit) begin
                values_q[4*dig_idx +: 4] <= dec.nibble;
                valid_q[dig_idx]         <= 1'b1;
                update_q                 <= 1'b1;
                idx_q                    <= dig_idx;
              end else if (is_single && seg_s == SEG7_BLANK) begin
                valid_q[dig_idx] <= 1'b0;
                update_q         <= 1'b1;
                idx_q            <= dig_idx;
              end else begin
                err_q <= 1'b1;
              end
            end
          end
        end
        ST_EVAL:  state_q <= changed ? ST_SETTLE : ST_HOLD;
        ST_HOLD:  if (changed) state_q <= ST_SETTLE;
        default:  state_q <= ST_SETTLE;
      endcase
      if (clear_i) begin
        values_q <= '0;
        valid_q  <= '0;
      end
    end
  end

  assign values_o      = values_q;
  assign digit_valid_o = valid_q;
  assign update_o      = update_q;
  assign update_idx_o  = idx_q;
  assign err_o         = err_q;

endmodule

// File: tb/tb_seg7_capture_decoder.sv
// Bench for seg7_capture_decoder: directed scenarios with literal expectations, then random
// bus traffic, all checked every cycle against a run-length reference model.
module tb_seg7_capture_decoder;

  localparam int DIGITS = 4;
  localparam int STABLE = 4;
  localparam int SYNC   = 2;

  logic        clk = 1'b0;
  logic        rst_n = 1'b0;
  logic [6:0]  seg_in = 7'h7F;
  logic [3:0]  dig_en = 4'hF;
  logic        clear = 1'b0;
  logic [15:0] values_o;
  logic [3:0]  digit_valid_o;
  logic        update_o;
  logic [1:0]  update_idx_o;
  logic        err_o;

  always #5 clk = ~clk;

  seg7_capture_decoder #(
    .DIGITS(DIGITS), .STABLE_CYCLES(STABLE), .SYNC_STAGES(SYNC)
  ) dut (
    .clk_i         (clk),
    .rst_ni        (rst_n),
    .seg_in_i      (seg_in),
    .dig_en_i      (dig_en),
    .clear_i       (clear),
    .values_o      (values_o),
    .digit_valid_o (digit_valid_o),
    .update_o      (update_o),
    .update_idx_o  (update_idx_o),
    .err_o         (err_o)
  );

  int tests = 0;
  int fails = 0;
  int upd_cnt = 0;
  int err_cnt = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  // Reference model: a word must be seen on the synced bus for STABLE consecutive
  // edges; it is then classified once, SYNC edges after it was applied.
  logic [6:0]  tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                            7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};
  logic [10:0] dline [SYNC];
  logic [10:0] m_last = '1;
  int          m_run = 1;
  logic [3:0]  m_vals [DIGITS];
  logic [3:0]  m_valid = '0;
  logic        m_upd = 1'b0;
  logic        m_err = 1'b0;
  logic [1:0]  m_idx = '0;
  logic [10:0] m_p;
  logic [15:0] m_pack;

  function automatic int code_of(input logic [6:0] s);
    int r = -1;
    for (int i = 0; i < 16; i++) if (tbl[i] == s) r = i;
    return r;
  endfunction

  initial begin
    for (int i = 0; i < SYNC; i++) dline[i] = '1;
    for (int i = 0; i < DIGITS; i++) m_vals[i] = '0;
  end

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      for (int i = 0; i < SYNC; i++) dline[i] = '1;
      for (int i = 0; i < DIGITS; i++) m_vals[i] = '0;
      m_last = '1; m_run = 1; m_valid = '0; m_upd = 0; m_err = 0; m_idx = '0;
    end else begin
      m_p = dline[SYNC-1];
      for (int i = SYNC-1; i > 0; i--) dline[i] = dline[i-1];
      dline[0] = {dig_en, seg_in};
      m_upd = 0; m_err = 0;
      if (m_p == m_last) begin
        if (m_run <= STABLE) m_run++;
      end else begin
        m_run = 1; m_last = m_p;
      end
      if (clear) begin
        for (int i = 0; i < DIGITS; i++) m_vals[i] = '0;
        m_valid = '0;
      end else if (m_run == STABLE) begin
        int nlow, k, c;
        nlow = 0; k = 0;
        for (int i = 0; i < DIGITS; i++) if (!m_p[7+i]) begin nlow++; k = i; end
        c = code_of(m_p[6:0]);
        if (nlow == 1 && c >= 0) begin
          m_vals[k] = c[3:0]; m_valid[k] = 1'b1; m_upd = 1; m_idx = k[1:0];
        end else if (nlow == 1 && m_p[6:0] == 7'h7F) begin
          m_valid[k] = 1'b0; m_upd = 1; m_idx = k[1:0];
        end else if (nlow != 0) begin
          m_err = 1;
        end
      end
    end
  end

  always @(posedge clk) begin
    #1;
    m_pack = {m_vals[3], m_vals[2], m_vals[1], m_vals[0]};
    check("values", values_o, m_pack);
    check("digit_valid", digit_valid_o, m_valid);
    check("update", update_o, m_upd);
    check("update_idx", update_idx_o, m_idx);
    check("err", err_o, m_err);
    if (update_o) upd_cnt++;
    if (err_o) err_cnt++;
  end

  task automatic hold(input int n);
    repeat (n) @(negedge clk);
  endtask

  task automatic drive(input logic [3:0] d, input logic [6:0] s);
    dig_en = d; seg_in = s;
  endtask

  task automatic watch_update(input int cycles, output int first, output int n);
    first = -1; n = 0;
    for (int k = 0; k < cycles; k++) begin
      @(negedge clk);
      if (update_o) begin
        n++;
        if (first < 0) first = k;
      end
    end
  endtask

  logic [6:0] scan_codes [4] = '{7'h79, 7'h30, 7'h0E, 7'h46};

  initial begin
    int first, n, u0, e0;
    hold(3);
    check("rst_values", values_o, 16'h0);
    check("rst_valid", digit_valid_o, 4'h0);
    check("rst_update", update_o, 1'b0);
    rst_n = 1'b1;
    hold(6);

    // 1: single digit write, latency
    drive(4'b1110, 7'h24);
    watch_update(12, first, n);
    check("t1_cycle", first, 5);
    check("t1_count", n, 1);
    check("t1_idx", update_idx_o, 0);
    check("t1_nib0", values_o[3:0], 4'h2);
    check("t1_valid", digit_valid_o, 4'b0001);
    $display("[TB] t1 single write: first=%0d count=%0d", first, n);

    // 2: scan all four digits with short gaps
    u0 = upd_cnt; e0 = err_cnt;
    for (int d = 0; d < 4; d++) begin
      drive(~(4'b0001 << d), scan_codes[d]);
      hold(8);
      drive(4'hF, 7'h7F);
      hold(2);
    end
    hold(6);
    check("t2_values", values_o, 16'hCF31);
    check("t2_valid", digit_valid_o, 4'hF);
    check("t2_updates", upd_cnt - u0, 4);
    check("t2_errs", err_cnt - e0, 0);
    $display("[TB] t2 scan: values=%h valid=%h", values_o, digit_valid_o);

    // 3: unknown pattern and multi-digit enable
    u0 = upd_cnt; e0 = err_cnt;
    drive(4'b1101, 7'h55);
    hold(10);
    check("t3_err1", err_cnt - e0, 1);
    drive(4'b1100, 7'h40);
    hold(10);
    check("t3_err2", err_cnt - e0, 2);
    check("t3_no_upd", upd_cnt - u0, 0);
    check("t3_values", values_o, 16'hCF31);
    check("t3_valid", digit_valid_o, 4'hF);
    $display("[TB] t3 errors: err=%0d", err_cnt - e0);

    // 4: short glitch filtered, then held blank
    drive(4'hF, 7'h7F);
    hold(8);
    u0 = upd_cnt; e0 = err_cnt;
    drive(4'b1011, 7'h00);
    hold(3);
    drive(4'b1011, 7'h7F);
    hold(10);
    check("t4_errs", err_cnt - e0, 0);
    check("t4_updates", upd_cnt - u0, 1);
    check("t4_idx", update_idx_o, 2);
    check("t4_valid", digit_valid_o, 4'hB);
    check("t4_values", values_o, 16'hCF31);
    $display("[TB] t4 glitch+blank: valid=%h", digit_valid_o);

    // 5: CLEAR on the update cycle wins
    u0 = upd_cnt;
    drive(4'b1110, 7'h79);
    hold(5);
    clear = 1'b1;
    hold(1);
    clear = 1'b0;
    hold(6);
    check("t5_no_upd", upd_cnt - u0, 0);
    check("t5_values", values_o, 16'h0);
    check("t5_valid", digit_valid_o, 4'h0);
    $display("[TB] t5 clear: values=%h", values_o);

    // 6: reset during settle
    drive(4'b0111, 7'h08);
    hold(8);
    check("t6_pre_nib3", values_o[15:12], 4'hA);
    drive(4'hF, 7'h7F);
    hold(2);
    drive(4'b1101, 7'h12);
    hold(2);
    rst_n = 1'b0;
    #1;
    check("t6_rst_values", values_o, 16'h0);
    check("t6_rst_valid", digit_valid_o, 4'h0);
    check("t6_rst_idx", update_idx_o, 0);
    check("t6_rst_upd", update_o, 1'b0);
    check("t6_rst_err", err_o, 1'b0);
    @(negedge clk);
    rst_n = 1'b1;
    watch_update(12, first, n);
    check("t6_cycle", first, 5);
    check("t6_count", n, 1);
    check("t6_nib1", values_o[7:4], 4'h5);
    check("t6_idx", update_idx_o, 1);
    $display("[TB] t6 reset mid-settle: first=%0d values=%h", first, values_o);

    // Random traffic: glitches, gaps, unknown codes, clears
    for (int t = 0; t < 300; t++) begin
      int r, h;
      logic [3:0] d;
      logic [6:0] s;
      r = $urandom_range(0, 9);
      if (r < 2)      d = 4'hF;
      else if (r < 8) d = ~(4'b0001 << $urandom_range(0, 3));
      else            d = 4'($urandom);
      r = $urandom_range(0, 19);
      if (r < 12)      s = tbl[$urandom_range(0, 15)];
      else if (r < 15) s = 7'h7F;
      else             s = 7'($urandom);
      h = $urandom_range(1, 9);
      drive(d, s);
      clear = ($urandom_range(0, 15) == 0);
      hold(1);
      clear = 1'b0;
      hold(h - 1);
      $display("[TB] rand %0d: dig=%b seg=%h hold=%0d values=%h valid=%h", t, d, s, h,
               values_o, digit_valid_o);
    end
    hold(10);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
